// File: rtl/tcdm_tx_beat_gen_ipa_pkg.sv
// Shared types and constants for the TCDM TX beat generator.
package mchan_ipa_pkg;

    typedef enum logic [0:0] {BG_IDLE, BG_RUN} bg_state_t;

    localparam int TCDM_WORD_BYTES = 4;

endpackage

// File: rtl/tcdm_tx_beat_gen_ipa.sv
// Splits one TX transfer command into per-word read beats and tracks
// how many accepted transfers are still waiting for their synch pulse.
module tcdm_tx_beat_gen_ipa
    import mchan_ipa_pkg::*;
#(
    parameter int TRANS_SID_WIDTH = 2,
    parameter int TCDM_ADD_WIDTH  = 12,
    parameter int LEN_WIDTH       = 8,
    parameter int MAX_OUTST       = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               cmd_req_i,
    output logic                               cmd_gnt_o,
    input  logic [TCDM_ADD_WIDTH-1:0]          cmd_add_i,
    input  logic [LEN_WIDTH-1:0]               cmd_len_i,
    input  logic [TRANS_SID_WIDTH-1:0]         cmd_sid_i,
    output logic                               beat_req_o,
    input  logic                               beat_gnt_i,
    output logic [TCDM_ADD_WIDTH-1:0]          beat_add_o,
    output logic [TRANS_SID_WIDTH-1:0]         beat_sid_o,
    output logic                               beat_eop_o,
    output logic                               beat_we_no,
    input  logic                               synch_req_i,
    output logic [$clog2(MAX_OUTST+1)-1:0]     outst_cnt_o,
    output logic                               busy_o
);

    localparam int CW = $clog2(MAX_OUTST+1);

    bg_state_t                  state_q, state_d;
    logic [TCDM_ADD_WIDTH-1:0]  add_q, add_d;
    logic [LEN_WIDTH-1:0]       rem_q, rem_d;
    logic [TRANS_SID_WIDTH-1:0] sid_q, sid_d;
    logic [CW-1:0]              cnt_q, cnt_d;

    logic run;
    logic cmd_gnt;
    logic synch_dec;

    always_comb begin
        run       = (state_q == BG_RUN);
        cmd_gnt   = ~rst_i & cmd_req_i & ~run & (cnt_q < CW'(MAX_OUTST));
        // A synch with nothing in flight is dropped unless it pairs with a grant.
        synch_dec = synch_req_i & ((cnt_q != '0) | cmd_gnt);
        cnt_d     = cnt_q + CW'(cmd_gnt) - CW'(synch_dec);

        state_d = state_q;
        add_d   = add_q;
        rem_d   = rem_q;
        sid_d   = sid_q;
        case (state_q)
            BG_IDLE: begin
                if (cmd_gnt) begin
                    add_d   = {cmd_add_i[TCDM_ADD_WIDTH-1:2], 2'b00};
                    rem_d   = cmd_len_i;
                    sid_d   = cmd_sid_i;
                    state_d = BG_RUN;
                end
            end
            BG_RUN: begin
                if (beat_gnt_i) begin
                    if (rem_q != '0) begin
                        add_d = add_q + TCDM_ADD_WIDTH'(TCDM_WORD_BYTES);
                        rem_d = rem_q - 1'b1;
                    end else begin
                        state_d = BG_IDLE;
                    end
                end
            end
            default: state_d = BG_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BG_IDLE;
            add_q   <= '0;
            rem_q   <= '0;
            sid_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            add_q   <= add_d;
            rem_q   <= rem_d;
            sid_q   <= sid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced quiet while reset is asserted, even before the first edge.
    assign cmd_gnt_o   = cmd_gnt;
    assign beat_req_o  = run & ~rst_i;
    assign beat_add_o  = rst_i ? '0 : add_q;
    assign beat_sid_o  = rst_i ? '0 : sid_q;
    assign beat_eop_o  = run & ~rst_i & (rem_q == '0);
    assign beat_we_no  = 1'b1;
    assign outst_cnt_o = rst_i ? '0 : cnt_q;
    assign busy_o      = ~rst_i & (run | (cnt_q != '0));

endmodule

// File: tb/tb_tcdm_tx_beat_gen_ipa.sv
// Bench for tcdm_tx_beat_gen_ipa: directed vector table, corner sequences,
// and random traffic checked against a beat-queue reference model.
module tb_tcdm_tx_beat_gen_ipa;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_req_i;
  logic        cmd_gnt_o;
  logic [11:0] cmd_add_i;
  logic [7:0]  cmd_len_i;
  logic [1:0]  cmd_sid_i;
  logic        beat_req_o;
  logic        beat_gnt_i;
  logic [11:0] beat_add_o;
  logic [1:0]  beat_sid_o;
  logic        beat_eop_o;
  logic        beat_we_no;
  logic        synch_req_i;
  logic [2:0]  outst_cnt_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  tcdm_tx_beat_gen_ipa #(
    .TRANS_SID_WIDTH(2), .TCDM_ADD_WIDTH(12), .LEN_WIDTH(8), .MAX_OUTST(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_req_i(cmd_req_i), .cmd_gnt_o(cmd_gnt_o),
    .cmd_add_i(cmd_add_i), .cmd_len_i(cmd_len_i), .cmd_sid_i(cmd_sid_i),
    .beat_req_o(beat_req_o), .beat_gnt_i(beat_gnt_i),
    .beat_add_o(beat_add_o), .beat_sid_o(beat_sid_o), .beat_eop_o(beat_eop_o),
    .beat_we_no(beat_we_no), .synch_req_i(synch_req_i),
    .outst_cnt_o(outst_cnt_o), .busy_o(busy_o)
  );

  // Reference model: every granted command expands into its full list of beats.
  typedef struct packed {
    logic [11:0] add;
    logic [1:0]  sid;
    logic        eop;
  } beat_t;

  beat_t exp_q[$];
  int    m_cnt = 0;
  int    vectors = 0;
  int    miscompares = 0;
  logic  last_gnt;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check against the model mid-cycle, advance the model at the edge.
  task automatic cyc(input bit rst, input bit req, input logic [11:0] add,
                     input logic [7:0] len, input logic [1:0] sid,
                     input bit gnt, input bit synch);
    bit    e_gnt;
    beat_t b;
    rst_i = rst; cmd_req_i = req; cmd_add_i = add; cmd_len_i = len;
    cmd_sid_i = sid; beat_gnt_i = gnt; synch_req_i = synch;
    e_gnt = !rst && req && (exp_q.size() == 0) && (m_cnt < 4);
    @(negedge clk_i);
    last_gnt = cmd_gnt_o;
    chk("cmd_gnt", int'(cmd_gnt_o), int'(e_gnt));
    chk("beat_req", int'(beat_req_o), int'(!rst && exp_q.size() != 0));
    chk("outst_cnt", int'(outst_cnt_o), rst ? 0 : m_cnt);
    chk("busy", int'(busy_o), int'(!rst && (exp_q.size() != 0 || m_cnt != 0)));
    chk("we_n", int'(beat_we_no), 1);
    if (!rst && exp_q.size() != 0) begin
      chk("beat_add", int'(beat_add_o), int'(exp_q[0].add));
      chk("beat_sid", int'(beat_sid_o), int'(exp_q[0].sid));
      chk("beat_eop", int'(beat_eop_o), int'(exp_q[0].eop));
    end
    @(posedge clk_i);
    if (rst) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      if (gnt && exp_q.size() != 0) void'(exp_q.pop_front());
      if (e_gnt) begin
        for (int i = 0; i <= int'(len); i++) begin
          b.add = 12'((int'(add) & 'hFFC) + 4 * i);
          b.sid = sid;
          b.eop = (i == int'(len));
          exp_q.push_back(b);
        end
      end
      if (e_gnt && !synch) m_cnt++;
      else if (!e_gnt && synch && m_cnt > 0) m_cnt--;
    end
    #1;
  endtask

  typedef struct {
    bit          rst, req;
    logic [11:0] add;
    logic [7:0]  len;
    logic [1:0]  sid;
    bit          gnt, synch;
    bit          e_req;
    logic [11:0] e_add;
    bit          e_eop, e_gnt;
    logic [2:0]  e_cnt;
  } tv_t;

  tv_t tv[15];

  function automatic tv_t mk(bit rst, bit req, logic [11:0] add, logic [7:0] len,
                             logic [1:0] sid, bit gnt, bit synch, bit e_req,
                             logic [11:0] e_add, bit e_eop, bit e_gnt, logic [2:0] e_cnt);
    tv_t t;
    t.rst = rst; t.req = req; t.add = add; t.len = len; t.sid = sid;
    t.gnt = gnt; t.synch = synch; t.e_req = e_req; t.e_add = e_add;
    t.e_eop = e_eop; t.e_gnt = e_gnt; t.e_cnt = e_cnt;
    return t;
  endfunction

  initial begin
    rst_i = 1'b1; cmd_req_i = 1'b0; cmd_add_i = '0; cmd_len_i = '0;
    cmd_sid_i = '0; beat_gnt_i = 1'b0; synch_req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // Directed table: single transfer, synch at zero, address wrap.
    tv[0]  = mk(1, 1, 12'h100, 3, 1, 1, 0, 0, 12'h000, 0, 0, 0);
    tv[1]  = mk(0, 1, 12'h100, 3, 1, 1, 0, 0, 12'h000, 0, 1, 0);
    tv[2]  = mk(0, 0, 12'h000, 0, 0, 1, 0, 1, 12'h100, 0, 0, 1);
    tv[3]  = mk(0, 0, 12'h000, 0, 0, 1, 0, 1, 12'h104, 0, 0, 1);
    tv[4]  = mk(0, 0, 12'h000, 0, 0, 1, 0, 1, 12'h108, 0, 0, 1);
    tv[5]  = mk(0, 0, 12'h000, 0, 0, 1, 0, 1, 12'h10C, 1, 0, 1);
    tv[6]  = mk(0, 0, 12'h000, 0, 0, 0, 1, 0, 12'h000, 0, 0, 1);
    tv[7]  = mk(0, 0, 12'h000, 0, 0, 0, 1, 0, 12'h000, 0, 0, 0);
    tv[8]  = mk(0, 1, 12'hFF9, 3, 2, 1, 0, 0, 12'h000, 0, 1, 0);
    tv[9]  = mk(0, 0, 12'h000, 0, 0, 1, 0, 1, 12'hFF8, 0, 0, 1);
    tv[10] = mk(0, 0, 12'h000, 0, 0, 1, 0, 1, 12'hFFC, 0, 0, 1);
    tv[11] = mk(0, 0, 12'h000, 0, 0, 1, 0, 1, 12'h000, 0, 0, 1);
    tv[12] = mk(0, 0, 12'h000, 0, 0, 1, 0, 1, 12'h004, 1, 0, 1);
    tv[13] = mk(0, 0, 12'h000, 0, 0, 0, 1, 0, 12'h000, 0, 0, 1);
    tv[14] = mk(0, 0, 12'h000, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      rst_i = tv[i].rst; cmd_req_i = tv[i].req; cmd_add_i = tv[i].add;
      cmd_len_i = tv[i].len; cmd_sid_i = tv[i].sid; beat_gnt_i = tv[i].gnt;
      synch_req_i = tv[i].synch;
      @(negedge clk_i);
      chk($sformatf("tv%0d_req", i), int'(beat_req_o), int'(tv[i].e_req));
      chk($sformatf("tv%0d_gnt", i), int'(cmd_gnt_o), int'(tv[i].e_gnt));
      chk($sformatf("tv%0d_cnt", i), int'(outst_cnt_o), int'(tv[i].e_cnt));
      if (tv[i].e_req) begin
        chk($sformatf("tv%0d_add", i), int'(beat_add_o), int'(tv[i].e_add));
        chk($sformatf("tv%0d_eop", i), int'(beat_eop_o), int'(tv[i].e_eop));
      end
      @(posedge clk_i);
      #1;
    end

    // Model-tracked sequences start from a clean reset.
    cyc(1, 0, 0, 0, 0, 0, 0);

    // Backpressure on the second beat for five cycles.
    cyc(0, 1, 12'h200, 3, 3, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    repeat (5) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("bp_hold_add", int'(beat_add_o), 'h204);
    end
    repeat (3) cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Outstanding limit: four one-word transfers, the fifth must wait for a synch.
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 12'(12'h400 + 16 * k), 0, 2'(k), 1, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
    end
    cyc(0, 1, 12'h480, 0, 1, 1, 0);
    chk("limit_5th_gnt", int'(last_gnt), 0);
    cyc(0, 1, 12'h480, 0, 1, 1, 1);
    chk("limit_synch_cycle_gnt", int'(last_gnt), 0);
    cyc(0, 1, 12'h480, 0, 1, 1, 0);
    chk("limit_5th_after_synch", int'(last_gnt), 1);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // Grant and synch together at count two leave the count unchanged.
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      cyc(0, 1, 12'h500, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
    end
    cyc(0, 1, 12'h600, 0, 1, 1, 1);
    chk("simul_cnt", int'(outst_cnt_o), 2);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // Reset during beat two of eight, then a fresh command from its own base.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 12'h300, 7, 2, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    rst_i = 1'b0;
    chk("rst_mid_req", int'(beat_req_o), 0);
    chk("rst_mid_busy", int'(busy_o), 0);
    cyc(0, 1, 12'h340, 1, 1, 1, 0);
    chk("fresh_base", int'(beat_add_o), 'h340);
    repeat (3) cyc(0, 0, 0, 0, 0, 1, 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 2) != 0,
          12'($urandom),
          8'($urandom_range(0, 6)),
          2'($urandom),
          $urandom_range(0, 9) < 7,
          $urandom_range(0, 5) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
